// File: rtl/conv_result_collector.sv
// conv_result_collector
// Receives the convolution engine's accumulator stream. Each pixel is
// arithmetically shifted right by SHIFT and saturated to DATA_WIDTH. It is then
// stored row-major in a local output feature-map buffer that has a registered
// read port.
// Optional build macro: CONV_COLLECT_RELU_EN applies a ReLU after the shift,
// so negative values are stored as 0.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for start; stream and conv_done ignored
// S_COLLECT  | accepting pixels into mem[count]
// S_COMPLETE | frame closed (full or short); further pixels flag overflow

module conv_result_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_H      = 3,
    parameter int OUT_W      = 3,
    parameter int SHIFT      = 0,
    localparam int TOTAL     = OUT_H * OUT_W,
    localparam int AW        = (TOTAL > 1) ? $clog2(TOTAL) : 1,
    localparam int CW        = $clog2(TOTAL + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic signed [ACC_WIDTH-1:0]  in_pixel_i,
    input  logic                         in_valid_i,
    input  logic                         conv_done_i,
    input  logic                         rd_en_i,
    input  logic        [AW-1:0]         rd_addr_i,
    output logic signed [DATA_WIDTH-1:0] rd_data_o,
    output logic        [CW-1:0]         count_o,
    output logic                         busy_o,
    output logic                         frame_done_o,
    output logic                         overflow_o,
    output logic                         short_frame_o
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMPLETE} state_t;

    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [AW:0]   TOTAL_A = (AW + 1)'(TOTAL);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   short_q, short_d;
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  q_data;
    logic signed [ACC_WIDTH-1:0] shifted, clipped;
    logic [DATA_WIDTH-1:0]  mem_q [TOTAL];
    logic [DATA_WIDTH-1:0]  rd_data_q;

    // Requantize the incoming accumulator: shift, optional ReLU, saturate.
    always_comb begin
        shifted = in_pixel_i >>> SHIFT;
`ifdef CONV_COLLECT_RELU_EN
        clipped = shifted[ACC_WIDTH-1] ? '0 : shifted;
`else
        clipped = shifted;
`endif
        if (clipped > SAT_MAX)
            q_data = SAT_MAX[DATA_WIDTH-1:0];
        else if (clipped < SAT_MIN)
            q_data = SAT_MIN[DATA_WIDTH-1:0];
        else
            q_data = clipped[DATA_WIDTH-1:0];
    end

    // Next-state, count and sticky-flag logic; start always wins over a pixel.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        short_d    = short_q;
        wr_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_COLLECT;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    short_d    = 1'b0;
                end
            end
            S_COLLECT: begin
                if (start_i) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                    short_d    = 1'b0;
                end else begin
                    if (in_valid_i) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                        if (count_d == TOTAL_C)
                            state_d = S_COMPLETE;
                    end
                    // count_d already includes any same-cycle pixel
                    if (conv_done_i) begin
                        state_d = S_COMPLETE;
                        if (count_d != TOTAL_C)
                            short_d = 1'b1;
                    end
                end
            end
            S_COMPLETE: begin
                if (start_i) begin
                    state_d    = S_COLLECT;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    short_d    = 1'b0;
                end else if (in_valid_i) begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            short_q    <= short_d;
        end
    end

    // Buffer write port; contents intentionally survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem_q[count_q[AW-1:0]] <= q_data;
    end

    // Registered read port; a same-address write in the same cycle returns old data.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            rd_data_q <= '0;
        else if (rd_en_i) begin
            if ({1'b0, rd_addr_i} < TOTAL_A)
                rd_data_q <= mem_q[rd_addr_i];
            else
                rd_data_q <= '0;
        end
    end

    assign rd_data_o     = rd_data_q;
    assign count_o       = count_q;
    assign busy_o        = (state_q == S_COLLECT);
    assign frame_done_o  = (state_q == S_COMPLETE);
    assign overflow_o    = overflow_q;
    assign short_frame_o = short_q;

endmodule

// File: tb/tb_conv_result_collector.sv
module tb_conv_result_collector;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [31:0] pix = '0;
    logic               valid = 1'b0;
    logic               done = 1'b0;
    logic               rd_en = 1'b0;
    logic [3:0]         rd_addr = '0;

    logic signed [7:0]  rd_data, rd_data2;
    logic [3:0]         count, count2;
    logic               busy, busy2, fd, fd2, ovf, ovf2, shrt, shrt2;

    int vectors = 0;
    int miscompares = 0;

    conv_result_collector u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_pixel_i(pix),
        .in_valid_i(valid), .conv_done_i(done), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .count_o(count), .busy_o(busy), .frame_done_o(fd),
        .overflow_o(ovf), .short_frame_o(shrt)
    );

    conv_result_collector #(.SHIFT(2)) u_sh2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_pixel_i(pix),
        .in_valid_i(valid), .conv_done_i(done), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data2), .count_o(count2), .busy_o(busy2), .frame_done_o(fd2),
        .overflow_o(ovf2), .short_frame_o(shrt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s, v;
        int          p;
        logic        d, re;
        logic [3:0]  a;
        int          e_cnt;
        logic        e_busy, e_fd;
        logic        chk_rd;
        int          e_rd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic s, logic v, int p, logic d, logic re, int a,
                                int e_cnt, logic e_busy, logic e_fd, logic chk_rd, int e_rd);
        vec_t r;
        r.s = s; r.v = v; r.p = p; r.d = d; r.re = re; r.a = 4'(a);
        r.e_cnt = e_cnt; r.e_busy = e_busy; r.e_fd = e_fd; r.chk_rd = chk_rd; r.e_rd = e_rd;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the negedge, let the posedge happen, return at next negedge.
    task automatic cyc(input logic s, input logic v, input int p, input logic d,
                       input logic re, input int a);
        start = s; valid = v; pix = p; done = d; rd_en = re; rd_addr = 4'(a);
        @(posedge clk);
        @(negedge clk);
        start = 0; valid = 0; done = 0; rd_en = 0;
    endtask

    task automatic chk_st(input string t, input int c, input logic b, input logic f,
                          input logic o, input logic sh);
        chk({t, "_count"}, int'(count), c);
        chk({t, "_busy"}, int'(busy), int'(b));
        chk({t, "_frame_done"}, int'(fd), int'(f));
        chk({t, "_overflow"}, int'(ovf), int'(o));
        chk({t, "_short"}, int'(shrt), int'(sh));
    endtask

    int sat_pix[7]  = '{300, -300, 20, -7, -5, 7, 200};
`ifdef CONV_COLLECT_RELU_EN
    int sat_exp0[7] = '{127, 0, 20, 0, 0, 7, 127};
    int sat_exp2[7] = '{75, 0, 5, 0, 0, 1, 50};
`else
    int sat_exp0[7] = '{127, -128, 20, -7, -5, 7, 127};
    int sat_exp2[7] = '{75, -75, 5, -2, -2, 1, 50};
`endif

    initial begin
        // reset state
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk_st("reset", 0, 0, 0, 0, 0);
        chk("reset_rd_data", int'(rd_data), 0);
        rst = 0;

        // table: full frame of 1..9, then reads 0..9 and a hold cycle
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 1; i <= 9; i++)
            vt.push_back(mk(0, 1, i, 0, 0, 0, i, (i != 9), (i == 9), 0, 0));
        for (int a = 0; a <= 8; a++)
            vt.push_back(mk(0, 0, 0, 0, 1, a, 9, 0, 1, 1, a + 1));
        vt.push_back(mk(0, 0, 0, 0, 1, 9, 9, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 4, 9, 0, 1, 1, 5));
        vt.push_back(mk(0, 0, 0, 0, 0, 7, 9, 0, 1, 1, 5));
        foreach (vt[k]) begin
            cyc(vt[k].s, vt[k].v, vt[k].p, vt[k].d, vt[k].re, int'(vt[k].a));
            chk($sformatf("vec%0d_count", k), int'(count), vt[k].e_cnt);
            chk($sformatf("vec%0d_busy", k), int'(busy), int'(vt[k].e_busy));
            chk($sformatf("vec%0d_frame_done", k), int'(fd), int'(vt[k].e_fd));
            if (vt[k].chk_rd)
                chk($sformatf("vec%0d_rd_data", k), int'(rd_data), vt[k].e_rd);
        end

        // saturation / shift / relu, closed early by conv_done -> short frame
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, sat_pix[i], 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk_st("short7", 7, 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 0, 1, i);
            chk($sformatf("sat_sh0_a%0d", i), int'(rd_data), sat_exp0[i]);
            chk($sformatf("sat_sh2_a%0d", i), int'(rd_data2), sat_exp2[i]);
        end

        // overflow after a full frame
        cyc(1, 0, 0, 0, 0, 0);
        chk_st("restart", 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 10 + i, 0, 0, 0);
        cyc(0, 1, 55, 0, 0, 0);
        chk_st("overflow", 9, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("overflow_mem0", int'(rd_data), 10);
        cyc(1, 0, 0, 0, 0, 0);
        chk_st("ovf_cleared", 0, 1, 0, 0, 0);

        // conv_done together with the 9th pixel: normal completion
        for (int i = 0; i < 8; i++) cyc(0, 1, i, 0, 0, 0);
        cyc(0, 1, 8, 1, 0, 0);
        chk_st("done_with_last", 9, 0, 1, 0, 0);

        // reset mid-frame, then IDLE ignores stream and conv_done
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 40 + i, 0, 0, 0);
        chk("mid_count", int'(count), 4);
        rst = 1;
        cyc(0, 0, 0, 0, 0, 0);
        rst = 0;
        chk_st("mid_reset", 0, 0, 0, 0, 0);
        cyc(0, 1, 66, 0, 0, 0);
        cyc(0, 1, 67, 1, 0, 0);
        chk_st("idle_ignore", 0, 0, 0, 0, 0);

        // start + in_valid in COLLECT: restart wins, pixel dropped
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 77, 0, 0, 0);
        chk("pre_restart_count", int'(count), 1);
        cyc(1, 1, 99, 0, 0, 0);
        chk_st("start_drop", 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("dropped_mem0", int'(rd_data), 77);

        // read and write of the same address in one cycle returns old data
        cyc(0, 1, 33, 0, 1, 0);
        chk("rw_same_old", int'(rd_data), 77);
        cyc(0, 0, 0, 0, 1, 0);
        chk("rw_same_new", int'(rd_data), 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
